// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command parser: opcodes, ASCII
// character constants, FSM state and character-class enums, and helpers that
// classify a received byte and map an operator character to its opcode.
// Optional build macro used by the parser slice: CALC_ECHO_EN.
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [7:0] ASCII_ZERO    = 8'h30;
   localparam logic [7:0] ASCII_NINE    = 8'h39;
   localparam logic [7:0] ASCII_PLUS    = 8'h2B;
   localparam logic [7:0] ASCII_MINUS   = 8'h2D;
   localparam logic [7:0] ASCII_STAR    = 8'h2A;
   localparam logic [7:0] ASCII_SLASH   = 8'h2F;
   localparam logic [7:0] ASCII_EQ      = 8'h3D;
   localparam logic [7:0] ASCII_CR      = 8'h0D;
   localparam logic [7:0] ASCII_SPACE   = 8'h20;
   localparam logic [7:0] ASCII_ESC     = 8'h1B;
   localparam logic [7:0] ASCII_LOWER_C = 8'h63;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_A_DIG,
      ST_OP,
      ST_B_DIG,
      ST_ISSUE
   } state_e;

   typedef enum logic [2:0] {
      CL_DIGIT,
      CL_OP,
      CL_TERM,
      CL_SPACE,
      CL_CLEAR,
      CL_ILLEGAL
   } cls_e;

   // Map a received byte onto its character class.
   function automatic cls_e classify(input logic [7:0] b);
      cls_e c;
      if (b >= ASCII_ZERO && b <= ASCII_NINE) begin
         c = CL_DIGIT;
      end else begin
         case (b)
            ASCII_PLUS, ASCII_MINUS, ASCII_STAR, ASCII_SLASH: c = CL_OP;
            ASCII_EQ, ASCII_CR:                               c = CL_TERM;
            ASCII_SPACE:                                      c = CL_SPACE;
            ASCII_ESC, ASCII_LOWER_C:                         c = CL_CLEAR;
            default:                                          c = CL_ILLEGAL;
         endcase
      end
      return c;
   endfunction

   // Opcode for an operator character; only called on bytes classed CL_OP.
   function automatic logic [1:0] op_of(input logic [7:0] b);
      logic [1:0] o;
      case (b)
         ASCII_MINUS: o = OP_SUB;
         ASCII_STAR:  o = OP_MUL;
         ASCII_SLASH: o = OP_DIV;
         default:     o = OP_ADD;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/calc_cmd_parser_if.sv
// Byte-stream input and command-output bundle of the calculator parser.
// Signals: rx_data/rx_valid (receiver bytes), operand_a/operand_b/op_code/
// cmd_valid/cmd_ready (command handshake), parse_error (reject pulse), and
// echo_data/echo_valid when CALC_ECHO_EN is defined.
// master = parser side, slave = byte source / command consumer side.
interface calc_cmd_parser_if #(
   parameter int unsigned OPW = 16
);
   logic [7:0]     rx_data;
   logic           rx_valid;
   logic [OPW-1:0] operand_a;
   logic [OPW-1:0] operand_b;
   logic [1:0]     op_code;
   logic           cmd_valid;
   logic           cmd_ready;
   logic           parse_error;
`ifdef CALC_ECHO_EN
   logic [7:0]     echo_data;
   logic           echo_valid;
`endif

   modport master (
      input  rx_data, rx_valid, cmd_ready,
      output operand_a, operand_b, op_code, cmd_valid, parse_error
`ifdef CALC_ECHO_EN
      , output echo_data, echo_valid
`endif
   );

   modport slave (
      output rx_data, rx_valid, cmd_ready,
      input  operand_a, operand_b, op_code, cmd_valid, parse_error
`ifdef CALC_ECHO_EN
      , input echo_data, echo_valid
`endif
   );
endinterface

// File: rtl/calc_dec_accum.sv
// Decimal accumulate step: acc*10+digit evaluated at OPW+4 bits, with a flag
// raised when the result no longer fits in OPW bits.
// Ports: acc_i (running value), digit_i (0..9), accum_c_o (low OPW bits of
// the result), ovf_c_o (result exceeds 2^OPW-1). Purely combinational.
module calc_dec_accum #(
   parameter int unsigned OPW = 16
) (
   input  logic [OPW-1:0] acc_i,
   input  logic [3:0]     digit_i,
   output logic [OPW-1:0] accum_c_o,
   output logic           ovf_c_o
);
   localparam int unsigned WW = OPW + 4;

   logic [WW-1:0] wide_c;

   always_comb begin
      wide_c    = WW'(acc_i) * WW'(4'd10) + WW'(digit_i);
      accum_c_o = wide_c[OPW-1:0];
      ovf_c_o   = |wide_c[WW-1:OPW];
   end
endmodule

// File: rtl/calc_cmd_parser.sv
// ASCII infix command parser: turns "<A><op><B>" terminated by '=' or CR into
// operands and an opcode presented over a valid/ready handshake; malformed
// input is discarded with a one-cycle parse_error pulse.
// Ports: clk, reset (async, active-low), bus (calc_cmd_parser_if.master).
// Build macro CALC_ECHO_EN adds a one-cycle echo of every accepted byte.
module calc_cmd_parser
   import calc_pkg::*;
#(
   parameter int unsigned OPW = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   calc_cmd_parser_if.master      bus
);
   state_e         state_q, state_d;
   logic [OPW-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
   logic [OPW-1:0] operand_a_q, operand_a_d, operand_b_q, operand_b_d;
   logic [1:0]     op_pend_q, op_pend_d, op_code_q, op_code_d;
   logic           cmd_valid_q, cmd_valid_d, parse_error_q, parse_error_d;
`ifdef CALC_ECHO_EN
   logic [7:0]     echo_data_q, echo_data_d;
   logic           echo_valid_q, echo_valid_d;
`endif

   cls_e           cls_c;
   logic [OPW-1:0] acc_in_c, acc_next_c;
   logic           ovf_c, err_c, accept_c;

   // One shared accumulator step; first digit of an operand starts from zero.
   calc_dec_accum #(.OPW(OPW)) u_accum (
      .acc_i     (acc_in_c),
      .digit_i   (bus.rx_data[3:0]),
      .accum_c_o (acc_next_c),
      .ovf_c_o   (ovf_c)
   );

   // Byte classification and per-state legality of the current byte.
   always_comb begin
      cls_c    = classify(bus.rx_data);
      acc_in_c = '0;
      if (state_q == ST_A_DIG) acc_in_c = acc_a_q;
      if (state_q == ST_B_DIG) acc_in_c = acc_b_q;
      accept_c = cmd_valid_q && bus.cmd_ready;
      err_c    = 1'b0;
      if (bus.rx_valid) begin
         unique case (cls_c)
            CL_DIGIT:            err_c = ovf_c;
            CL_SPACE, CL_CLEAR:  err_c = 1'b0;
            CL_OP:               err_c = (state_q != ST_A_DIG);
            CL_TERM:             err_c = (state_q != ST_B_DIG);
            default:             err_c = 1'b1;
         endcase
         // Everything arriving while a command is pending is dropped.
         if (state_q == ST_ISSUE) err_c = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (state_q == ST_ISSUE) begin
         if (accept_c) state_d = ST_IDLE;
      end else if (bus.rx_valid) begin
         if (err_c) begin
            state_d = ST_IDLE;
         end else begin
            unique case (cls_c)
               CL_DIGIT: begin
                  if (state_q == ST_IDLE) state_d = ST_A_DIG;
                  if (state_q == ST_OP)   state_d = ST_B_DIG;
               end
               CL_OP:    state_d = ST_OP;
               CL_TERM:  state_d = ST_ISSUE;
               CL_CLEAR: state_d = ST_IDLE;
               default:  state_d = state_q;
            endcase
         end
      end
   end

   // Datapath / output next values.
   always_comb begin
      acc_a_d       = acc_a_q;
      acc_b_d       = acc_b_q;
      op_pend_d     = op_pend_q;
      operand_a_d   = operand_a_q;
      operand_b_d   = operand_b_q;
      op_code_d     = op_code_q;
      cmd_valid_d   = cmd_valid_q;
      parse_error_d = bus.rx_valid && err_c;
`ifdef CALC_ECHO_EN
      echo_valid_d  = bus.rx_valid && !err_c;
      echo_data_d   = (bus.rx_valid && !err_c) ? bus.rx_data : echo_data_q;
`endif
      if (state_q == ST_ISSUE) begin
         if (accept_c) cmd_valid_d = 1'b0;
      end else if (bus.rx_valid) begin
         if (err_c || cls_c == CL_CLEAR) begin
            acc_a_d = '0;
            acc_b_d = '0;
         end else begin
            unique case (cls_c)
               CL_DIGIT: begin
                  if (state_q == ST_IDLE || state_q == ST_A_DIG) acc_a_d = acc_next_c;
                  else                                           acc_b_d = acc_next_c;
               end
               CL_OP:    op_pend_d = op_of(bus.rx_data);
               CL_TERM: begin
                  operand_a_d = acc_a_q;
                  operand_b_d = acc_b_q;
                  op_code_d   = op_pend_q;
                  cmd_valid_d = 1'b1;
                  acc_a_d     = '0;
                  acc_b_d     = '0;
               end
               default: ;
            endcase
         end
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_a_q       <= '0;
         acc_b_q       <= '0;
         op_pend_q     <= OP_ADD;
         operand_a_q   <= '0;
         operand_b_q   <= '0;
         op_code_q     <= OP_ADD;
         cmd_valid_q   <= 1'b0;
         parse_error_q <= 1'b0;
`ifdef CALC_ECHO_EN
         echo_data_q   <= '0;
         echo_valid_q  <= 1'b0;
`endif
      end else begin
         acc_a_q       <= acc_a_d;
         acc_b_q       <= acc_b_d;
         op_pend_q     <= op_pend_d;
         operand_a_q   <= operand_a_d;
         operand_b_q   <= operand_b_d;
         op_code_q     <= op_code_d;
         cmd_valid_q   <= cmd_valid_d;
         parse_error_q <= parse_error_d;
`ifdef CALC_ECHO_EN
         echo_data_q   <= echo_data_d;
         echo_valid_q  <= echo_valid_d;
`endif
      end
   end

   assign bus.operand_a   = operand_a_q;
   assign bus.operand_b   = operand_b_q;
   assign bus.op_code     = op_code_q;
   assign bus.cmd_valid   = cmd_valid_q;
   assign bus.parse_error = parse_error_q;
`ifdef CALC_ECHO_EN
   assign bus.echo_data   = echo_data_q;
   assign bus.echo_valid  = echo_valid_q;
`endif
endmodule

// File: tb/tb_calc_cmd_parser.sv
// Scoreboard bench for calc_cmd_parser: stimulus pushes expected commands and
// per-byte error/echo expectations; a negedge monitor pops and compares.
module tb_calc_cmd_parser;
   import calc_pkg::*;

   localparam int unsigned OPW = 16;

   typedef struct packed {
      logic [OPW-1:0] a;
      logic [OPW-1:0] b;
      logic [1:0]     op;
   } cmd_t;

   typedef struct packed {
      logic [7:0] data;
      logic       err;
   } byte_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic rxv_d;

   cmd_t  exp_q[$];
   byte_t byt_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   calc_cmd_parser_if #(.OPW(OPW)) bus();

   calc_cmd_parser #(.OPW(OPW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // A byte was consumed on the last rising edge.
   always @(posedge clk or negedge reset) begin
      if (!reset) rxv_d <= 1'b0;
      else        rxv_d <= bus.rx_valid;
   end

   // Monitor: byte-slot checks and command checks against the scoreboard.
   always @(negedge clk) begin
      byte_t b;
      if (reset) begin
         if (rxv_d) begin
            if (byt_q.size() == 0) begin
               chk("byte_queue_empty", 32'(byt_q.size()), 32'd1);
            end else begin
               b = byt_q.pop_front();
               chk("parse_error", 32'(bus.parse_error), 32'(b.err));
`ifdef CALC_ECHO_EN
               chk("echo_valid", 32'(bus.echo_valid), 32'(!b.err));
               if (!b.err) chk("echo_data", 32'(bus.echo_data), 32'(b.data));
`endif
            end
         end else begin
            if (bus.parse_error) chk("parse_error_unexpected", 32'(bus.parse_error), 32'd0);
`ifdef CALC_ECHO_EN
            if (bus.echo_valid) chk("echo_valid_unexpected", 32'(bus.echo_valid), 32'd0);
`endif
         end
         if (bus.cmd_valid) begin
            if (exp_q.size() == 0) begin
               chk("cmd_unexpected", 32'(bus.cmd_valid), 32'd0);
            end else begin
               chk("operand_a", 32'(bus.operand_a), 32'(exp_q[0].a));
               chk("operand_b", 32'(bus.operand_b), 32'(exp_q[0].b));
               chk("op_code",   32'(bus.op_code),   32'(exp_q[0].op));
               if (bus.cmd_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic send(input logic [7:0] b, input logic e);
      @(posedge clk); #1;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      byt_q.push_back('{data: b, err: e});
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
   endtask

   // Bit i of emask marks character i as expected to be rejected.
   task automatic send_str(input string s, input logic [31:0] emask);
      for (int i = 0; i < s.len(); i++) send(s[i], emask[i]);
   endtask

   task automatic expect_cmd(input int unsigned a, input int unsigned b, input logic [1:0] op);
      exp_q.push_back('{a: OPW'(a), b: OPW'(b), op: op});
   endtask

   // Wait (bounded) for all expected commands to be accepted.
   task automatic drain();
      for (int i = 0; i < 60 && (exp_q.size() != 0 || bus.cmd_valid); i++) @(posedge clk);
      @(posedge clk); #1;
      chk("drain_cmd_queue", 32'(exp_q.size()), 32'd0);
      chk("drain_byte_queue", 32'(byt_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.rx_data   = 8'h00;
      bus.rx_valid  = 1'b0;
      bus.cmd_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_operand_a",   32'(bus.operand_a),   32'd0);
      chk("rst_operand_b",   32'(bus.operand_b),   32'd0);
      chk("rst_op_code",     32'(bus.op_code),     32'd0);
      chk("rst_cmd_valid",   32'(bus.cmd_valid),   32'd0);
      chk("rst_parse_error", 32'(bus.parse_error), 32'd0);
      reset = 1'b1;

      // Basic add with consumer always ready.
      expect_cmd(12, 34, OP_ADD);
      send_str("12+34=", 32'h0);
      drain();

      // Held command with spaces, CR terminator and a byte dropped mid-hold.
      bus.cmd_ready = 1'b0;
      expect_cmd(7, 6, OP_MUL);
      send_str("7 * 6", 32'h0);
      send(ASCII_CR, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("hold_valid", 32'(bus.cmd_valid), 32'd1);
         @(posedge clk); #1;
      end
      send("9", 1'b1);
      for (int i = 0; i < 2; i++) begin
         chk("hold_valid_after_drop", 32'(bus.cmd_valid), 32'd1);
         @(posedge clk); #1;
      end
      bus.cmd_ready = 1'b1;
      drain();
      expect_cmd(3, 2, OP_SUB);
      send_str("3-2=", 32'h0);
      drain();

      // Largest operand, then overflow by one.
      expect_cmd(65535, 1, OP_SUB);
      send_str("65535-1=", 32'h0);
      drain();
      send_str("65536+1=", 32'hB0);
      drain();

      // Misplaced operator, missing operand, illegal character, recovery.
      send_str("+5=", 32'h5);
      send_str("5/=", 32'h4);
      send_str("5x", 32'h2);
      expect_cmd(8, 2, OP_DIV);
      send_str("8/2=", 32'h0);
      drain();

      // ESC and 'c' clears, leading zeros.
      expect_cmd(4, 1, OP_SUB);
      send_str("12+3", 32'h0);
      send(ASCII_ESC, 1'b0);
      send_str("4-1=", 32'h0);
      drain();
      expect_cmd(7, 0, OP_ADD);
      send_str("5*c007+0=", 32'h0);
      drain();

      expect_cmd(0, 65535, OP_MUL);
      send_str("0*65535=", 32'h0);
      drain();
      expect_cmd(1, 1, OP_ADD);
      send_str("1+1=", 32'h0);
      drain();

      // Asynchronous reset mid-sequence.
      expect_cmd(2, 9, OP_MUL);
      send_str("2*9=", 32'h0);
      drain();
      send_str("9*9", 32'h0);
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      chk("mid_rst_operand_a",   32'(bus.operand_a),   32'd0);
      chk("mid_rst_operand_b",   32'(bus.operand_b),   32'd0);
      chk("mid_rst_op_code",     32'(bus.op_code),     32'd0);
      chk("mid_rst_cmd_valid",   32'(bus.cmd_valid),   32'd0);
      chk("mid_rst_parse_error", 32'(bus.parse_error), 32'd0);
`ifdef CALC_ECHO_EN
      chk("mid_rst_echo_valid",  32'(bus.echo_valid),  32'd0);
      chk("mid_rst_echo_data",   32'(bus.echo_data),   32'd0);
`endif
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      send("=", 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("no_cmd_after_reset", 32'(bus.cmd_valid), 32'd0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/calc_cmd_parser.md
Name: calc_cmd_parser

Overview:
- Sits directly downstream of the calculator's UART byte receiver and consumes its byte/valid-pulse stream.
- Parses ASCII infix commands of the form `<A><op><B>` terminated by `=` or CR into binary operands and an opcode.
- Presents each parsed command to the arithmetic unit over a valid/ready handshake.
- Malformed input is discarded and flagged.

Parameters:
- OPW, 16: operand width in bits; operands are unsigned decimal, range 0..2^OPW-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; block is held in reset while reset==0.
- rx_data  in  8  received ASCII byte; meaningful only when rx_valid==1.
- rx_valid  in  1  single-cycle strobe from the receiver, one per byte.
- operand_a  out  OPW  parsed first operand; stable while cmd_valid==1.
- operand_b  out  OPW  parsed second operand; stable while cmd_valid==1.
- op_code  out  2  00 add, 01 sub, 10 mul, 11 div.
- cmd_valid  out  1  command available; held until accepted.
- cmd_ready  in  1  consumer accepts the command when cmd_valid && cmd_ready.
- parse_error  out  1  single-cycle pulse per rejected byte or sequence.

Behaviour:
- Reset values: operand_a=0, operand_b=0, op_code=00, cmd_valid=0, parse_error=0; FSM=IDLE; accumulators cleared.
- Character classes:
  - digit: 0x30-0x39.
  - op: `+` 0x2B, `-` 0x2D, `*` 0x2A, `/` 0x2F.
  - term: `=` 0x3D or CR 0x0D.
  - space 0x20: ignored in every state except ISSUE.
  - clear: ESC 0x1B or `c` 0x63.
  - anything else: illegal.
- Only cycles with rx_valid==1 advance the parser. rx_data is ignored otherwise.
- FSM transitions:
  - IDLE: digit -> acc_a=digit, go to A_DIG. Op, term or illegal -> error. Clear -> stay.
  - A_DIG: digit -> acc_a=acc_a*10+digit. Op -> latch op_code, go to OP. Term or illegal -> error.
  - OP: digit -> acc_b=digit, go to B_DIG. Op, term or illegal -> error.
  - B_DIG: digit -> acc_b=acc_b*10+digit. Term -> load operand_a/operand_b/op_code from accumulators, set cmd_valid, go to ISSUE. Op or illegal -> error.
  - ISSUE: cmd_valid held at 1.
    - cmd_valid && cmd_ready: cmd_valid cleared next cycle, return to IDLE.
    - Any byte arriving in ISSUE, including space and clear, is dropped and pulses parse_error; state unchanged.
- Latency: cmd_valid rises on the clock edge following the rx_valid cycle carrying the terminator. Ready may be high in that same first valid cycle; the handshake then completes in one cycle.
- Clear (in IDLE, A_DIG, OP, B_DIG): accumulators zeroed, go to IDLE, no error.
- Error action: parse_error=1 for exactly one cycle (the cycle after the offending rx_valid), accumulators zeroed, go to IDLE. The offending byte is not reinterpreted.
- Overflow:
  - acc*10+digit is computed at OPW+4 bits.
  - If the result exceeds 2^OPW-1, this is an error (not wrap or saturate).
  - Value exactly 2^OPW-1 is legal.
- Leading zeros are permitted ("007" = 7).
- operand_a, operand_b and op_code change only on the ISSUE entry edge. They hold their last values after handshake.
- Asynchronous reset mid-sequence or mid-ISSUE discards everything. No command is emitted after reset release until a full new sequence arrives.

Optional Feature:
- Macro CALC_ECHO_EN.
- When defined: extra outputs echo_data[7:0] and echo_valid.
  - Every byte that does not cause an error and is not dropped (including space and clear) is echoed.
  - echo_valid is a one-cycle pulse, one cycle after its rx_valid, with echo_data equal to that byte.
  - Reset values: echo_valid=0, echo_data=0.
- When undefined: those ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared package calc_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV (2-bit);
  - ASCII constants for digits base, operators, `=`, CR, space, ESC, `c`;
  - FSM state enum.
- One natural sub-module, calc_dec_accum: combinational acc*10+digit with overflow flag, parameterised by OPW. Instantiated twice (A and B) or shared via mux.

Test Plan:
- Bytes "12+34=" with cmd_ready=1 -> one cmd_valid pulse; operand_a=12, operand_b=34, op_code=00; parse_error never set.
- Bytes "7 * 6\r" with cmd_ready=0 for 5 cycles, then 1 -> cmd_valid held 5+ cycles, outputs stable at a=7, b=6, op_code=10; byte "9" sent during the hold -> one parse_error pulse, and the next command parses normally.
- OPW=16: "65535-1=" -> a=65535, b=1, op_code=01. Then "65536+1=" -> parse_error on the final "6", and no cmd_valid for that line.
- "+5=" -> parse_error on "+". "5/=" -> parse_error on "=". "5x" -> parse_error on "x". Subsequent "8/2=" -> a=8, b=2, op_code=11.
- "12+3" then ESC then "4-1=" -> no error; single command a=4, b=1, op_code=01.
- reset driven low after "9*9" -> all outputs return to reset values immediately; after release "=" gives parse_error and no cmd_valid. With CALC_ECHO_EN: "1+1=" -> four echo_valid pulses, each matching its byte, one cycle after its rx_valid.
